// File: rtl/ov7670_pattern_gen.sv
// ov7670_pattern_gen: OV7670-style RGB565 timing emulator driving deterministic test patterns
module ov7670_pattern_gen #(
   parameter int H_ACTIVE    = 160,
   parameter int H_BLANK     = 64,
   parameter int VSYNC_LINES = 3,
   parameter int V_BACK      = 17,
   parameter int V_ACTIVE    = 120,
   parameter int V_FRONT     = 10
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        enable,
   input  logic [1:0]  pattern,
   input  logic [15:0] solid_color,
   output logic        vsync,
   output logic        href,
   output logic [7:0]  px_data,
   output logic        frame_done,
   output logic [15:0] frame_count
);
   localparam int H_TOTAL = 2*H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;
   localparam int V_START = VSYNC_LINES + V_BACK;
   localparam int V_END   = V_START + V_ACTIVE;
   localparam int BAR_W   = H_ACTIVE / 8;
   localparam int HW      = $clog2(H_TOTAL) > 10 ? $clog2(H_TOTAL) : 10;
   localparam int VW      = $clog2(V_TOTAL) > 9 ? $clog2(V_TOTAL) : 9;
   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};
   typedef enum logic {IDLE, RUN} state_t;
   state_t          state;
   logic [HW-1:0]   h_cnt, nh;
   logic [VW-1:0]   v_cnt, nv;
   logic [1:0]      pat, npat;
   logic [15:0]     solid, nsolid, rgb;
   logic [4:0]      b_px, nb_px;
   logic [2:0]      b_idx, nb_idx;
   logic            h_last, f_last, restart, run_next, active, y3, new_px, bar_end;
   // Outputs are registered from the next position so they line up with the counters.
   always_comb begin
      h_last   = h_cnt == HW'(H_TOTAL-1);
      f_last   = h_last && v_cnt == VW'(V_TOTAL-1);
      restart  = state == IDLE || f_last;
      run_next = restart ? enable : 1'b1;
      nh       = (restart || h_last) ? '0 : h_cnt + 1'b1;
      nv       = restart ? '0 : h_last ? v_cnt + 1'b1 : v_cnt;
      npat     = restart ? pattern : pat;
      nsolid   = restart ? solid_color : solid;
      new_px   = !nh[0];
      bar_end  = b_px == 5'(BAR_W-1);
      nb_px    = nh == '0 ? '0 : new_px ? (bar_end ? '0 : b_px + 1'b1) : b_px;
      nb_idx   = nh == '0 ? '0 : (new_px && bar_end) ? b_idx + 1'b1 : b_idx;
      y3       = 1'((nv - VW'(V_START)) >> 3);
      active   = nv >= VW'(V_START) && nv < VW'(V_END) && nh < HW'(2*H_ACTIVE);
      rgb      = npat == 2'd0 ? nsolid :
                 npat == 2'd1 ? BARS[nb_idx] :
                 npat == 2'd2 ? {nh[8:4], nh[8:3], nh[8:4]} :
                 {16{nh[4] ^ y3}};
   end
   always_ff @(posedge pclk) begin
      if (rst) begin
         state       <= IDLE;
         h_cnt       <= '0;
         v_cnt       <= '0;
         pat         <= '0;
         solid       <= '0;
         b_px        <= '0;
         b_idx       <= '0;
         vsync       <= 1'b0;
         href        <= 1'b0;
         px_data     <= '0;
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done <= state == RUN && f_last;
         if (state == RUN && f_last)
            frame_count <= frame_count + 1'b1;
         if (run_next) begin
            state   <= RUN;
            h_cnt   <= nh;
            v_cnt   <= nv;
            pat     <= npat;
            solid   <= nsolid;
            b_px    <= nb_px;
            b_idx   <= nb_idx;
            vsync   <= nv < VW'(VSYNC_LINES);
            href    <= active;
            px_data <= active ? (nh[0] ? rgb[7:0] : rgb[15:8]) : '0;
         end else begin
            state   <= IDLE;
            h_cnt   <= '0;
            v_cnt   <= '0;
            b_px    <= '0;
            b_idx   <= '0;
            vsync   <= 1'b0;
            href    <= 1'b0;
            px_data <= '0;
         end
      end
   end
endmodule

// File: doc/ov7670_pattern_gen.md
Name: ov7670_pattern_gen

Overview:
- Synthesizable OV7670 emulator; sits directly upstream of the camera capture stage.
- Drives vsync/href/px_data with the same timing shape as the sensor, in RGB565 two-byte-per-pixel format.
- Lets the capture → frame buffer → display path be simulated and brought up on the board with no camera attached.
- Produces deterministic test patterns at a 160x120 default resolution.

Parameters:
- H_ACTIVE, 160: active pixels per line; must be a multiple of 8 and ≤ 256.
- H_BLANK, 64: pclk cycles with href low after each line's active bytes.
- VSYNC_LINES, 3: line periods with vsync high at frame start.
- V_BACK, 17: idle line periods after vsync.
- V_ACTIVE, 120: active lines per frame.
- V_FRONT, 10: idle line periods after the last active line.
- Derived: H_TOTAL = 2*H_ACTIVE + H_BLANK (384 default); V_TOTAL = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT (150 default).

Ports:
- pclk  in  1  pixel/byte clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  run request; sampled only in IDLE and at frame end.
- pattern  in  2  0 = solid, 1 = colour bars, 2 = horizontal gradient, 3 = checkerboard.
- solid_color  in  16  RGB565 value for pattern 0.
- vsync  out  1  frame sync, high during the first VSYNC_LINES line periods.
- href  out  1  high during the 2*H_ACTIVE byte cycles of each active line.
- px_data  out  8  pixel byte; 0 whenever href = 0.
- frame_done  out  1  one-cycle pulse after the last cycle of a frame.
- frame_count  out  16  completed frames, wraps mod 2^16.

Behaviour:
- Reset (rst = 1 at an edge): next edge sets vsync = href = frame_done = 0, px_data = 0, frame_count = 0. Counters clear, FSM enters IDLE. Applies equally mid-line and mid-frame; no partial line is finished.
- FSM states:
  - IDLE: all outputs 0.
  - IDLE → RUN on the first edge with enable = 1. That edge is frame cycle 0, and vsync = 1 is already visible after it.
  - RUN: h_cnt counts 0..H_TOTAL-1; on wrap, v_cnt counts 0..V_TOTAL-1. On the final cycle (v = V_TOTAL-1, h = H_TOTAL-1), the next edge does three things:
    - pulses frame_done = 1 for exactly one cycle;
    - increments frame_count (0xFFFF → 0x0000);
    - returns to frame cycle 0 if enable = 1, otherwise goes to IDLE.
  - An enable drop mid-frame never truncates the frame.
- All outputs are registered and change only on the rising pclk edge. The capture stage samples them on the following rising edge.
- vsync = 1 for v < VSYNC_LINES (whole line periods), so it is high for VSYNC_LINES*H_TOTAL cycles.
- Active line: v in [VSYNC_LINES+V_BACK, VSYNC_LINES+V_BACK+V_ACTIVE-1].
  - y = v - (VSYNC_LINES+V_BACK).
  - href = 1 for h < 2*H_ACTIVE; x = h>>1.
  - Even h outputs rgb[15:8]; odd h outputs rgb[7:0] (high byte first).
- Patterns; pattern and solid_color are latched at frame cycle 0 and held for the whole frame (no tearing):
  - 0, solid: rgb = latched solid_color.
  - 1, colour bars: 8 bars, each H_ACTIVE/8 pixels wide, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a counter reloaded per line; no divider.
  - 2, gradient: with x8 = x[7:0], rgb = {x8[7:3], x8[7:2], x8[7:3]}.
  - 3, checkerboard: rgb = (x[3] ^ y[3]) ? FFFF : 0000.
- Width rules: h_cnt is ≥ 10 bits and v_cnt ≥ 9 bits, both sized from the parameters. No counter overflows for legal parameters.

Test Plan:
- Solid colour framing: rst 2 cycles, enable = 1, pattern = 0, solid_color = F81F →
  - vsync high 1152 cycles;
  - 120 href pulses of 320 cycles each, separated by 64 low cycles;
  - bytes alternate F8, 1F;
  - frame_done every 57600 cycles;
  - frame_count = 3 after 3 frames.
- Colour bars: pattern = 1 → each active line starts with 40 bytes FF, followed by 20 pairs FF, E0; the last 40 bytes are 00; px_data = 00 whenever href = 0.
- Checkerboard: pattern = 3 → line y = 0 is pixels 0–7 = 0000 and pixels 8–15 = FFFF; line y = 8, pixel 0 = FFFF.
- Pattern latch: switch pattern 0 → 2 at active line 50 → current frame stays solid; the next frame's pixel 128 = {10000, 100000, 10000} (bytes 84, 10).
- Enable drop: enable falls at line 60 → frame completes, frame_done pulses once, frame_count increments, then vsync/href remain 0 indefinitely. Re-raising enable starts with vsync on the next edge.
- Mid-line reset: rst asserted at h = 100 of an active line → next edge href = 0, px_data = 0, frame_count = 0. After release with enable = 1, a full new frame starts at cycle 0.
